// File: rtl/wb_pkg.sv
// Shared types and constants for the Wishbone initiator slice.
// Command bundle, FSM state encoding and harness register map.
package wb_pkg;

   typedef struct packed {
      logic        we;
      logic [31:0] adr;
      logic [31:0] dat;
      logic [3:0]  sel;
   } wb_cmd_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUS  = 2'd1,
      RESP = 2'd2
   } wb_state_t;

   localparam logic [31:0] ADDR_ACTIVE = 32'h3000_0000;
   localparam logic [31:0] ADDR_WS2812 = 32'h3000_0100;
   localparam logic [31:0] ADDR_7SEG   = 32'h3000_0200;
   localparam logic [31:0] ADDR_FREQ   = 32'h3000_0400;

   // Writes carry no read data back to the requester.
   function automatic logic [31:0] rsp_data(
      input logic        we,
      input logic [31:0] bus_dat
   );
      return we ? 32'h0 : bus_dat;
   endfunction

endpackage

// File: rtl/wb_cmd_fifo.sv
// Synchronous command FIFO holding wb_cmd_t entries.
// Ports: push/push_cmd in, pop in, head out, full/empty flags out.
module wb_cmd_fifo
   import wb_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic    clk,
   input  logic    reset,
   input  logic    push,
   input  wb_cmd_t push_cmd,
   input  logic    pop,
   output wb_cmd_t head,
   output logic    full,
   output logic    empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   wb_cmd_t     mem_q [DEPTH];
   logic [AW:0] wr_ptr_q;
   logic [AW:0] wr_ptr_d;
   logic [AW:0] rd_ptr_q;
   logic [AW:0] rd_ptr_d;
   logic        push_ok;
   logic        pop_ok;

   // Extra pointer MSB distinguishes full from empty.
   assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign head    = mem_q[rd_ptr_q[AW-1:0]];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push_ok) begin
         wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
      end
      if (pop_ok) begin
         rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem_q[wr_ptr_q[AW-1:0]] <= push_cmd;
      end
   end

endmodule

// File: rtl/wishbone_initiator.sv
// Wishbone classic initiator: queued single read/write commands.
// Ports: cmd valid/ready in, rsp valid/ready out, wbm_* bus, busy.
module wishbone_initiator
   import wb_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255,
   parameter int FIFO_DEPTH     = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_we,
   input  logic [31:0] cmd_adr,
   input  logic [31:0] cmd_dat,
   input  logic [3:0]  cmd_sel,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_dat,
   output logic        rsp_timeout,
   output logic        wbm_cyc_o,
   output logic        wbm_stb_o,
   output logic        wbm_we_o,
   output logic [3:0]  wbm_sel_o,
   output logic [31:0] wbm_adr_o,
   output logic [31:0] wbm_dat_o,
   input  logic        wbm_ack_i,
   input  logic [31:0] wbm_dat_i,
   output logic        busy
);

   localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

   wb_state_t   state_q;
   wb_state_t   state_d;
   logic [15:0] cnt_q;
   logic [15:0] cnt_d;
   logic        cyc_q;
   logic        cyc_d;
   logic        we_q;
   logic        we_d;
   logic [3:0]  sel_q;
   logic [3:0]  sel_d;
   logic [31:0] adr_q;
   logic [31:0] adr_d;
   logic [31:0] dat_q;
   logic [31:0] dat_d;
   logic [31:0] rdat_q;
   logic [31:0] rdat_d;
   logic        rto_q;
   logic        rto_d;

   wb_cmd_t     push_cmd;
   wb_cmd_t     head;
   logic        fifo_full;
   logic        fifo_empty;
   logic        push;
   logic        pop;

   assign cmd_ready = !fifo_full;
   assign push      = cmd_valid && !fifo_full;
   assign push_cmd  = '{we:  cmd_we,
                        adr: cmd_adr,
                        dat: cmd_dat,
                        sel: cmd_sel};

   wb_cmd_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .push     (push),
      .push_cmd (push_cmd),
      .pop      (pop),
      .head     (head),
      .full     (fifo_full),
      .empty    (fifo_empty)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      cyc_d   = cyc_q;
      we_d    = we_q;
      sel_d   = sel_q;
      adr_d   = adr_q;
      dat_d   = dat_q;
      rdat_d  = rdat_q;
      rto_d   = rto_q;
      pop     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               pop     = 1'b1;
               cyc_d   = 1'b1;
               we_d    = head.we;
               sel_d   = head.sel;
               adr_d   = head.adr;
               dat_d   = head.dat;
               cnt_d   = '0;
               state_d = BUS;
            end
         end
         BUS: begin
            // Ack is checked first so it wins on the timeout edge.
            if (wbm_ack_i) begin
               cyc_d   = 1'b0;
               rdat_d  = rsp_data(we_q, wbm_dat_i);
               rto_d   = 1'b0;
               state_d = RESP;
            end else if (cnt_q == TO_LAST) begin
               cyc_d   = 1'b0;
               rdat_d  = '0;
               rto_d   = 1'b1;
               state_d = RESP;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         RESP: begin
            // RESP plus IDLE keep cyc low for two cycles, so a
            // lingering registered ack is never seen as fresh.
            if (rsp_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         cyc_q   <= 1'b0;
         we_q    <= 1'b0;
         sel_q   <= '0;
         adr_q   <= '0;
         dat_q   <= '0;
         rdat_q  <= '0;
         rto_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         cyc_q   <= cyc_d;
         we_q    <= we_d;
         sel_q   <= sel_d;
         adr_q   <= adr_d;
         dat_q   <= dat_d;
         rdat_q  <= rdat_d;
         rto_q   <= rto_d;
      end
   end

   assign wbm_cyc_o   = cyc_q;
   assign wbm_stb_o   = cyc_q;
   assign wbm_we_o    = we_q;
   assign wbm_sel_o   = sel_q;
   assign wbm_adr_o   = adr_q;
   assign wbm_dat_o   = dat_q;
   assign rsp_valid   = (state_q == RESP);
   assign rsp_dat     = rdat_q;
   assign rsp_timeout = rto_q;
   assign busy        = !fifo_empty || (state_q != IDLE);

endmodule

// File: doc/wishbone_initiator.md
# wishbone_initiator

Wishbone classic-cycle initiator that executes queued single read/write commands against a Wishbone slave such as the multi-project harness slave port. It is the bus-master end of that interface, used by bench/bring-up logic and by LA-driven control paths to program project-select and per-project registers. Commands enter through a valid/ready port into a small FIFO. Each command becomes exactly one bus cycle. Results, including read data and timeout status, leave through a valid/ready response port.

## Interface
Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles cyc/stb stay asserted without ack (range 2..65535).
- FIFO_DEPTH, 4: command FIFO entries (power of two, ≥2).

Ports:
- clk  in  1  clock; everything is on the rising edge.
- reset  in  1  reset, synchronous, active-high.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  equals !fifo_full.
- cmd_we  in  1  1 = write, 0 = read.
- cmd_adr  in  32  byte address.
- cmd_dat  in  32  write data.
- cmd_sel  in  4  byte selects.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed.
- rsp_dat  out  32  read data (0 for writes and timeouts).
- rsp_timeout  out  1  no ack within TIMEOUT_CYCLES.
- wbm_cyc_o, wbm_stb_o  out  1  driven identically.
- wbm_we_o  out  1  bus write enable.
- wbm_sel_o  out  4  bus byte selects.
- wbm_adr_o  out  32  bus address.
- wbm_dat_o  out  32  bus write data.
- wbm_ack_i  in  1  slave ack.
- wbm_dat_i  in  32  slave read data.
- busy  out  1  FIFO non-empty or state ≠ IDLE.

## Operation
- Push: cmd_valid && cmd_ready at an edge writes {we, adr, dat, sel} to the FIFO. When full, cmd_ready is 0 and no push occurs.
- FSM states: IDLE, BUS, RESP.
  - IDLE: if the FIFO is non-empty, pop the head, load the bus registers, assert cyc/stb, clear the timeout counter, and go to BUS.
  - BUS: cyc, stb, we, sel, adr and dat are registered and held stable.
    - Ack sampled high: drop cyc/stb at that edge. Capture wbm_dat_i into rsp_dat if it is a read, else capture 0. Set rsp_timeout=0. Go to RESP.
    - No ack: increment the counter. When the counter reaches TIMEOUT_CYCLES-1 with no ack, drop cyc/stb, set rsp_dat=0 and rsp_timeout=1, and go to RESP.
    - Ack on the timeout edge: ack wins.
  - RESP: rsp_valid=1. Outputs hold until rsp_ready. On rsp_valid && rsp_ready, go to IDLE and clear rsp_valid.
- cyc is low for at least 2 cycles between transactions (RESP plus IDLE). This guarantees that a registered ack which lingers one cycle after cyc drops is never mistaken for the next cycle's ack.
- Push and pop in the same cycle are legal when not full; occupancy is unchanged.
- Reset (any state, including mid-BUS): cyc/stb drop at the reset edge, the FIFO is flushed, and the FSM goes to IDLE.
- Reset values: all outputs 0 except cmd_ready=1.

## Timing
- Command accepted at edge N.
  - cyc/stb go high after edge N+1.
  - With a slave that registers ack one cycle after stb (harness behaviour), ack is sampled at edge N+3.
  - cyc drops and rsp_valid rises after edge N+3.
- Latency from accept to rsp_valid = 3 cycles with that slave. cyc is high for exactly 2 cycles.
- Timeout: cyc high for exactly TIMEOUT_CYCLES cycles, then rsp_valid rises at the next edge.
- Back-to-back with rsp_ready tied high: one transaction per 2 + (bus cycles) clocks.
- Capacity: FIFO_DEPTH queued commands plus one in flight.

## Structure
- Shared package wb_pkg:
  - wb_cmd_t struct {we, adr[31:0], dat[31:0], sel[3:0]}.
  - State enum {IDLE, BUS, RESP}.
  - Harness address constants: ADDR_ACTIVE 0x30000000, ADDR_WS2812 0x30000100, ADDR_7SEG 0x30000200, ADDR_FREQ 0x30000400.
- Sub-module wb_cmd_fifo: synchronous FIFO of wb_cmd_t, with full/empty and registered head output, parameterised by FIFO_DEPTH. The initiator FSM stays in the top module.

## Test plan
- Write ADDR_ACTIVE, dat=3, sel=4'b0001, against the harness: cyc high 2 cycles, rsp_valid 3 cycles after accept, rsp_timeout=0, rsp_dat=0, harness active_project=3.
- Then read ADDR_ACTIVE: rsp_dat=32'h3, rsp_timeout=0, wbm_we_o=0 throughout the cycle.
- Read 0x30000300 (no ack) with TIMEOUT_CYCLES=16: cyc high exactly 16 cycles, rsp_timeout=1, rsp_dat=0.
- Push 6 commands with rsp_ready=0, FIFO_DEPTH=4: 5 accepted (1 in flight + 4 queued), cmd_ready=0 at the 6th. Releasing rsp_ready drains all 5 in order, with cyc low ≥2 cycles between each.
- Slave model acks exactly on the timeout edge: response has rsp_timeout=0 and the captured data.
- Assert reset mid-BUS with 2 commands queued: cyc=0 the next cycle, busy=0, rsp_valid=0, cmd_ready=1, and no further bus cycles occur.
